// File: rtl/sdram_ex_pkg.sv
// sdram_ex_pkg
// Shared definitions for the SDRAM example driver's LFSR data path.
// The generator (write side) and the checker (read side) both use
// lfsr8_next() so the two ends always agree on the sequence.
//   - lfsr8_chk_state_e : checker state encoding
//   - LFSR8_TAPS        : Galois XOR mask applied when d[7] is set
//   - lfsr8_next()      : one step of x^8+x^4+x^3+x^2+1 (Galois form)
package sdram_ex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_VERIFY  = 2'd3
    } lfsr8_chk_state_e;

    localparam logic [7:0] LFSR8_TAPS = 8'h1C;

    // Rotate left so d7 feeds bit 0, then fold d7 into taps 2,3,4.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] d);
        return {d[6:0], d[7]} ^ (d[7] ? LFSR8_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/sdram_ex_sat_cnt.sv
// sdram_ex_sat_cnt
// Saturating up-counter with synchronous clear. Clear beats increment,
// and the count sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset (count -> 0)
//   clear - synchronous clear (count -> 0)
//   inc   - add one unless already saturated
//   count - current value
module sdram_ex_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, then a guarded increment that holds at max.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sdram_ex_lfsr8_checker.sv
// sdram_ex_lfsr8_checker
// Read-side checker for the example driver's 8-bit LFSR pattern. It
// regenerates the expected byte stream and compares it with read-back data,
// reporting mismatch pulses, a sticky fail flag and saturating counters.
// Optional build macro: LFSR8_CHK_SELFSYNC_EN adds ACQUIRE/VERIFY states so
// the checker can lock onto a stream from any phase, and drop lock after
// LOSS_THRESH consecutive mismatches.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   enable              - low holds the checker in IDLE with expected=SEED
//   load, ldata         - overwrite the expected byte (no compare that cycle)
//   clear               - zero err_count, word_count and fail
//   in_valid, in_data   - received byte to check
//   expected            - byte the checker expects next
//   mismatch            - one-cycle pulse per counted mismatch
//   locked              - checker is in CHECK
//   fail                - sticky error flag
//   err_count           - saturating mismatch count
//   word_count          - saturating count of words compared in CHECK
module sdram_ex_lfsr8_checker
    import sdram_ex_pkg::*;
#(
    parameter logic [31:0] SEED         = 32'd32,
    parameter int          ERR_W        = 16,
    parameter int          LOSS_THRESH  = 4,
    parameter int          SYNC_MATCHES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [7:0]       ldata,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic [7:0]       expected,
    output logic             mismatch,
    output logic             locked,
    output logic             fail,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      word_count
);

    localparam logic [7:0] SEED8 = SEED[7:0];

    lfsr8_chk_state_e state_q, state_d;
    logic [7:0]       expected_q, expected_d;
    logic             mismatch_q, mismatch_d;
    logic             fail_q, fail_d;
    logic             err_inc;
    logic             word_inc;

`ifdef LFSR8_CHK_SELFSYNC_EN
    localparam logic [3:0] LOSS_N = 4'(LOSS_THRESH);
    localparam logic [3:0] SYNC_N = 4'(SYNC_MATCHES);

    logic [3:0] match_run_q, match_run_d;
    logic [3:0] miss_run_q, miss_run_d;
`else
    // Lock-tracking parameters only matter in the self-sync build.
    logic unused_cfg;
    assign unused_cfg = ^{4'(LOSS_THRESH), 4'(SYNC_MATCHES)};
`endif

    // Main next-state logic. Priority is enable low, then load, then a
    // valid word. Only a CHECK-state compare ever increments the counters.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        err_inc    = 1'b0;
        word_inc   = 1'b0;
`ifdef LFSR8_CHK_SELFSYNC_EN
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
`endif
        if (!enable) begin
            state_d    = ST_IDLE;
            expected_d = SEED8;
`ifdef LFSR8_CHK_SELFSYNC_EN
            match_run_d = 4'd0;
            miss_run_d  = 4'd0;
`endif
        end else if (load) begin
            expected_d = ldata;
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef LFSR8_CHK_SELFSYNC_EN
                    state_d = ST_ACQUIRE;
`else
                    state_d = ST_CHECK;
`endif
                end
                ST_CHECK: begin
                    if (in_valid) begin
                        word_inc   = 1'b1;
                        expected_d = lfsr8_next(expected_q);
                        if (in_data != expected_q) begin
                            err_inc = 1'b1;
`ifdef LFSR8_CHK_SELFSYNC_EN
                            // Too many misses in a row means we have slipped
                            // phase; resynchronise from the incoming data.
                            if ((miss_run_q + 4'd1) >= LOSS_N) begin
                                state_d    = ST_ACQUIRE;
                                miss_run_d = 4'd0;
                            end else begin
                                miss_run_d = miss_run_q + 4'd1;
                            end
`endif
                        end
`ifdef LFSR8_CHK_SELFSYNC_EN
                        else begin
                            miss_run_d = 4'd0;
                        end
`endif
                    end
                end
`ifdef LFSR8_CHK_SELFSYNC_EN
                ST_ACQUIRE: begin
                    if (in_valid) begin
                        expected_d  = lfsr8_next(in_data);
                        match_run_d = 4'd0;
                        state_d     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (in_valid) begin
                        if (in_data == expected_q) begin
                            expected_d = lfsr8_next(expected_q);
                            if ((match_run_q + 4'd1) >= SYNC_N) begin
                                state_d     = ST_CHECK;
                                match_run_d = 4'd0;
                                miss_run_d  = 4'd0;
                            end else begin
                                match_run_d = match_run_q + 4'd1;
                            end
                        end else begin
                            // Re-seed from what actually arrived and start over.
                            expected_d  = lfsr8_next(in_data);
                            match_run_d = 4'd0;
                        end
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Status flags. The mismatch pulse still fires when clear wins the
    // same cycle, so the pass/fail logic never misses an event edge.
    always_comb begin
        mismatch_d = err_inc;
        fail_d     = clear ? 1'b0 : (fail_q | err_inc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            expected_q <= SEED8;
            mismatch_q <= 1'b0;
            fail_q     <= 1'b0;
`ifdef LFSR8_CHK_SELFSYNC_EN
            match_run_q <= 4'd0;
            miss_run_q  <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
            fail_q     <= fail_d;
`ifdef LFSR8_CHK_SELFSYNC_EN
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
`endif
        end
    end

    sdram_ex_sat_cnt #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (err_inc),
        .count (err_count)
    );

    sdram_ex_sat_cnt #(.W(32)) u_word_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (word_inc),
        .count (word_count)
    );

    assign expected = expected_q;
    assign mismatch = mismatch_q;
    assign locked   = (state_q == ST_CHECK);
    assign fail     = fail_q;

endmodule
